// File: rtl/seg_display_ctrl_if.sv
// Bus between the debug-source fabric and the display-source controller.
// master: drives page sources, button, auto-rotate enable and override request/data;
//         observes the selected word, page index and override flag.
// slave : the controller side (seg_display_ctrl).
interface seg_display_ctrl_if;
  logic [31:0] i_src0;
  logic [31:0] i_src1;
  logic [31:0] i_src2;
  logic [31:0] i_src3;
  logic        i_btn_next;
  logic        i_auto_en;
  logic        i_ovr_req;
  logic [31:0] i_ovr_data;
  logic [31:0] o_data;
  logic [1:0]  o_page;
  logic        o_ovr_active;

  modport master (
    output i_src0, i_src1, i_src2, i_src3,
    output i_btn_next, i_auto_en, i_ovr_req, i_ovr_data,
    input  o_data, o_page, o_ovr_active
  );

  modport slave (
    input  i_src0, i_src1, i_src2, i_src3,
    input  i_btn_next, i_auto_en, i_ovr_req, i_ovr_data,
    output o_data, o_page, o_ovr_active
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Display-source controller in front of the 8-digit seven-segment scanner.
// Selects one of four 32-bit debug pages, advanced by a debounced "next"
// button or an auto-rotate timer; a level-sensitive override request
// pre-empts the page display for at least MIN_HOLD+1 cycles.
// Ports:
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   bus     - slave side: sources, button, auto enable, override req/data in;
//             o_data (registered word), o_page, o_ovr_active out
module seg_display_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd999_999,
  parameter logic [26:0] ROTATE_INTERVAL = 27'd99_999_999,
  parameter logic [26:0] MIN_HOLD        = 27'd49_999_999
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  seg_display_ctrl_if.slave bus
);

  typedef enum logic {IDLE, OVR} state_t;

  state_t      state;
  logic        btn_sync1, btn_sync2, btn_level, btn_pulse;
  logic [19:0] db_cnt;
  logic [26:0] rot_cnt;
  logic [26:0] hold_cnt;
  logic [31:0] ovr_reg;
  logic [1:0]  page;
  logic [31:0] src_sel;
  logic        rot_pulse;
  logic        page_adv;

  // Button: 2-flop synchronizer, then accept a new level only after it has
  // differed from the accepted level for DEBOUNCE_CYCLES+1 cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_sync1 <= bus.i_btn_next;
      btn_sync2 <= btn_sync1;
      btn_pulse <= 1'b0;
      if (btn_sync2 != btn_level) begin
        if (db_cnt == DEBOUNCE_CYCLES) begin
          btn_level <= btn_sync2;
          db_cnt    <= '0;
          btn_pulse <= btn_sync2;   // rising acceptance only
        end else begin
          db_cnt <= db_cnt + 20'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign rot_pulse = bus.i_auto_en && (state == IDLE) && (rot_cnt == ROTATE_INTERVAL);
  assign page_adv  = (state == IDLE) && (btn_pulse || rot_pulse);

  // A manual advance restarts the rotate period so the next auto step is a
  // full interval away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rot_cnt <= '0;
    end else if (!bus.i_auto_en || (state == OVR) || btn_pulse) begin
      rot_cnt <= '0;
    end else if (rot_cnt == ROTATE_INTERVAL) begin
      rot_cnt <= '0;
    end else begin
      rot_cnt <= rot_cnt + 27'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      page <= '0;
    end else if (page_adv) begin
      page <= page + 2'd1;
    end
  end

  always_comb begin
    src_sel = bus.i_src0;
    case (page)
      2'd1:    src_sel = bus.i_src1;
      2'd2:    src_sel = bus.i_src2;
      2'd3:    src_sel = bus.i_src3;
      default: src_sel = bus.i_src0;
    endcase
  end

  // Override FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      ovr_reg          <= '0;
      hold_cnt         <= '0;
      bus.o_data       <= '0;
      bus.o_ovr_active <= 1'b0;
    end else begin
      bus.o_data <= (state == OVR) ? ovr_reg : src_sel;
      case (state)
        IDLE: begin
          if (bus.i_ovr_req) begin
            state            <= OVR;
            ovr_reg          <= bus.i_ovr_data;
            hold_cnt         <= '0;
            bus.o_ovr_active <= 1'b1;
          end
        end
        OVR: begin
          if (bus.i_ovr_req) begin
            ovr_reg <= bus.i_ovr_data;
          end
          if (hold_cnt != MIN_HOLD) begin
            hold_cnt <= hold_cnt + 27'd1;
          end
          if (!bus.i_ovr_req && (hold_cnt == MIN_HOLD)) begin
            state            <= IDLE;
            bus.o_ovr_active <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          bus.o_ovr_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_page = page;

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

  logic clk;
  logic rst_n;

  seg_display_ctrl_if bus();

  seg_display_ctrl #(
    .DEBOUNCE_CYCLES(20'd3),
    .ROTATE_INTERVAL(27'd9),
    .MIN_HOLD(27'd4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned kind;   // 0 o_data, 1 o_page, 2 o_ovr_active
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned pg    = 0;

  function automatic logic [31:0] w(input int unsigned p);
    return 32'h1111_1111 * (p % 4);
  endfunction

  task automatic push1(input string tag, input int unsigned kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input string tag, input logic [31:0] d, input int unsigned p, input logic a);
    push1({tag, ".data"}, 0, d);
    push1({tag, ".page"}, 1, 32'(p % 4));
    push1({tag, ".ovr"},  2, {31'b0, a});
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] obs;
      e = sb.pop_front();
      case (e.kind)
        0:       obs = bus.o_data;
        1:       obs = {30'b0, bus.o_page};
        default: obs = {31'b0, bus.o_ovr_active};
      endcase
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Clean press from a settled-low button: pulse after 6 edges, page on the
  // 7th, data on the 8th; then release and let the low level settle.
  task automatic press(input string tag);
    bus.i_btn_next = 1'b1;
    ticks(6);
    push1({tag, ".before"}, 1, 32'(pg % 4));
    drain();
    tick();
    pg = (pg + 1) % 4;
    push1({tag, ".page"}, 1, 32'(pg));
    drain();
    tick();
    push1({tag, ".data"}, 0, w(pg));
    drain();
    bus.i_btn_next = 1'b0;
    ticks(8);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_src0     = 32'h0000_0000;
    bus.i_src1     = 32'h1111_1111;
    bus.i_src2     = 32'h2222_2222;
    bus.i_src3     = 32'h3333_3333;
    bus.i_btn_next = 1'b0;
    bus.i_auto_en  = 1'b0;
    bus.i_ovr_req  = 1'b0;
    bus.i_ovr_data = '0;

    // Reset state
    ticks(2);
    push_all("reset", 32'h0, 0, 1'b0);
    drain();
    rst_n = 1'b1;
    tick();
    push_all("post_reset", 32'h0, 0, 1'b0);
    drain();

    // Bounce rejection: 10 segments of 2 cycles, then stable high
    for (int i = 0; i < 10; i++) begin
      bus.i_btn_next = (i % 2 == 0);
      ticks(2);
    end
    push1("bounce.nopage", 1, 32'd0);
    drain();
    bus.i_btn_next = 1'b1;
    ticks(6);
    push1("bounce.edge6", 1, 32'd0);
    drain();
    tick();
    pg = 1;
    push1("bounce.page", 1, 32'd1);
    drain();
    tick();
    push1("bounce.data", 0, 32'h1111_1111);
    drain();
    bus.i_btn_next = 1'b0;
    ticks(8);
    push1("release.nopulse", 1, 32'd1);
    drain();

    // Four presses, wrapping through 3->0
    press("press1");
    press("press2");
    press("press3");
    press("press4");

    // Coincidence of button pulse and timer terminal count
    bus.i_auto_en = 1'b1;
    ticks(3);
    bus.i_btn_next = 1'b1;
    ticks(6);
    push1("coinc.before", 1, 32'(pg));
    drain();
    tick();
    pg = (pg + 1) % 4;
    push1("coinc.once", 1, 32'(pg));
    drain();
    bus.i_btn_next = 1'b0;

    // Auto-rotate: one advance every 10 cycles
    for (int k = 0; k < 4; k++) begin
      ticks(9);
      push1("auto.hold", 1, 32'(pg));
      push1("auto.data", 0, w(pg));
      drain();
      tick();
      pg = (pg + 1) % 4;
      push1("auto.step", 1, 32'(pg));
      drain();
    end
    bus.i_auto_en = 1'b0;
    ticks(30);
    push1("auto.frozen", 1, 32'(pg));
    push1("auto.frozen_data", 0, w(pg));
    drain();

    // Short override with a button press whose pulse lands inside OVR
    bus.i_btn_next = 1'b1;
    tick();
    bus.i_ovr_req  = 1'b1;
    bus.i_ovr_data = 32'hDEAD_BEEF;
    tick();
    push_all("ovs.enter", w(pg), pg, 1'b1);
    drain();
    bus.i_ovr_req = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      push_all("ovs.cyc", (c == 7) ? w(pg) : 32'hDEAD_BEEF, pg, (c <= 5));
      drain();
    end
    bus.i_btn_next = 1'b0;
    bus.i_ovr_data = '0;
    ticks(10);
    push_all("ovs.after", w(pg), pg, 1'b0);
    drain();

    // Long override: data changes mid-request
    bus.i_ovr_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      bus.i_ovr_data = (c >= 6) ? 32'hC0DE_0001 : 32'hC0DE_0000;
      tick();
      if (c == 1)
        push_all("ovl.enter", w(pg), pg, 1'b1);
      else
        push_all("ovl.cyc", (c - 1 >= 6) ? 32'hC0DE_0001 : 32'hC0DE_0000, pg, 1'b1);
      drain();
    end
    bus.i_ovr_req = 1'b0;
    tick();
    push_all("ovl.exit", 32'hC0DE_0001, pg, 1'b0);
    drain();
    tick();
    push_all("ovl.resume", w(pg), pg, 1'b0);
    drain();

    // Asynchronous reset in the middle of an override
    bus.i_ovr_req  = 1'b1;
    bus.i_ovr_data = 32'hC0DE_0002;
    ticks(2);
    push_all("midrun.active", 32'hC0DE_0002, pg, 1'b1);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    push_all("midrun.async", 32'h0, 0, 1'b0);
    drain();
    bus.i_ovr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    pg = 0;
    tick();
    push_all("midrun.release", 32'h0, 0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
